// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if: command, alu-drive and result signal bundle for alu_issue_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid_in;
  logic             cmd_ready_out;
  logic [4:0]       cmd_sel_in;
  logic             cmd_carry_in;
  logic [WIDTH-1:0] cmd_a_in;
  logic [WIDTH-1:0] cmd_b_in;

  logic [4:0]       alu_sel_out;
  logic             alu_carry_out;
  logic [WIDTH-1:0] alu_a_out;
  logic [WIDTH-1:0] alu_b_out;
  logic [WIDTH-1:0] alu_y_in;

  logic             res_valid_out;
  logic             res_ready_in;
  logic [WIDTH-1:0] res_y_out;
  logic [4:0]       res_sel_out;
  logic             res_zero_out;
  logic             busy_out;

  modport slave (
    input  cmd_valid_in, cmd_sel_in, cmd_carry_in, cmd_a_in, cmd_b_in,
    input  alu_y_in, res_ready_in,
    output cmd_ready_out, alu_sel_out, alu_carry_out, alu_a_out, alu_b_out,
    output res_valid_out, res_y_out, res_sel_out, res_zero_out, busy_out
  );

  modport master (
    output cmd_valid_in, cmd_sel_in, cmd_carry_in, cmd_a_in, cmd_b_in,
    output alu_y_in, res_ready_in,
    input  cmd_ready_out, alu_sel_out, alu_carry_out, alu_a_out, alu_b_out,
    input  res_valid_out, res_y_out, res_sel_out, res_zero_out, busy_out
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl: FIFO-buffered issue stage that drives a combinational alu and
// captures its result after a fixed settle time. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  alu_issue_ctrl_if.slave   bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int SCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CMDW = 5 + 1 + 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ready_en_q, ready_en_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CMDW-1:0]   mem_q [DEPTH];
  logic [CMDW-1:0]   mem_d [DEPTH];
  logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [4:0]        alu_sel_q, alu_sel_d;
  logic              alu_carry_q, alu_carry_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_y_q, res_y_d;
  logic [4:0]        res_sel_q, res_sel_d;

  logic              cmd_ready;
  logic              push;
  logic              pop;

  // Full flag looks only at the registered count so res_ready_in never reaches cmd_ready_out.
  assign cmd_ready = ready_en_q & (count_q != CW'(DEPTH));
  assign push      = bus.cmd_valid_in & cmd_ready;

  always_comb begin
    state_d      = state_q;
    ready_en_d   = 1'b1;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    settle_cnt_d = settle_cnt_q;
    alu_sel_d    = alu_sel_q;
    alu_carry_d  = alu_carry_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_valid_d  = res_valid_q;
    res_y_d      = res_y_q;
    res_sel_d    = res_sel_q;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          res_y_d     = bus.alu_y_in;
          res_sel_d   = alu_sel_q;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
        end
      end
      ST_RESULT: begin
        if (res_valid_q & bus.res_ready_in) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      {alu_sel_d, alu_carry_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + AW'(1);
      settle_cnt_d = SCW'(SETTLE - 1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = {bus.cmd_sel_in, bus.cmd_carry_in, bus.cmd_a_in, bus.cmd_b_in};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      ready_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      settle_cnt_q <= '0;
      alu_sel_q    <= '0;
      alu_carry_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_y_q      <= '0;
      res_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= ready_en_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
      settle_cnt_q <= settle_cnt_d;
      alu_sel_q    <= alu_sel_d;
      alu_carry_q  <= alu_carry_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_valid_q  <= res_valid_d;
      res_y_q      <= res_y_d;
      res_sel_q    <= res_sel_d;
    end
  end

  assign bus.cmd_ready_out = cmd_ready;
  assign bus.alu_sel_out   = alu_sel_q;
  assign bus.alu_carry_out = alu_carry_q;
  assign bus.alu_a_out     = alu_a_q;
  assign bus.alu_b_out     = alu_b_q;
  assign bus.res_valid_out = res_valid_q;
  assign bus.res_y_out     = res_y_q;
  assign bus.res_sel_out   = res_sel_q;
  // Gated by valid so the flag reads 0 out of reset and between results.
  assign bus.res_zero_out  = res_valid_q & (res_y_q == '0);
  assign bus.busy_out      = (state_q != ST_IDLE) | (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with an adder alu stub
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] y;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(8)) bus ();

  alu_issue_ctrl #(.WIDTH(8), .DEPTH(4), .SETTLE(1)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  assign bus.alu_y_in = bus.alu_a_out + bus.alu_b_out + {7'd0, bus.alu_carry_out};

  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   res_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record accepted commands, compare consumed results in order.
  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid_in && bus.cmd_ready_out)
      exp_q.push_back(exp_t'{bus.cmd_sel_in,
                             8'(bus.cmd_a_in + bus.cmd_b_in + {7'd0, bus.cmd_carry_in})});
    if (rst_n && bus.res_valid_out && bus.res_ready_in) begin
      checks++;
      res_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got y=%h sel=%0d, required no result", bus.res_y_out, bus.res_sel_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.res_y_out !== e.y || bus.res_sel_out !== e.sel || bus.res_zero_out !== (e.y == 8'h00))
          $display("FAIL sb_result: got y=%h sel=%0d z=%b, required y=%h sel=%0d z=%b",
                   bus.res_y_out, bus.res_sel_out, bus.res_zero_out, e.y, e.sel, (e.y == 8'h00));
        else
          passed++;
      end
    end
  end

  task automatic push_cmd(input logic [4:0] sel, input logic c, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    bus.cmd_valid_in = 1'b1;
    bus.cmd_sel_in   = sel;
    bus.cmd_carry_in = c;
    bus.cmd_a_in     = a;
    bus.cmd_b_in     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready_out;
      @(posedge clk); #1;
      if (ok) break;
    end
    bus.cmd_valid_in = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL push_timeout: got cmd_ready_out=0 for 100 cycles, required 1");
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy_out && !bus.res_valid_out) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) $display("FAIL %s: got %0d pending busy=%b, required 0 pending busy=0", name, exp_q.size(), bus.busy_out);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_ready_out, bus.alu_sel_out, bus.alu_carry_out, bus.alu_a_out, bus.alu_b_out,
         bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.res_zero_out, bus.busy_out} !== '0)
      $display("FAIL reset_outputs: got ready=%b alu_a=%h res_valid=%b zero=%b busy=%b, required all 0",
               bus.cmd_ready_out, bus.alu_a_out, bus.res_valid_out, bus.res_zero_out, bus.busy_out);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_out !== 1'b0) $display("FAIL ready_after_release: got %b, required 0", bus.cmd_ready_out);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_out !== 1'b1) $display("FAIL ready_one_edge_later: got %b, required 1", bus.cmd_ready_out);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bus.res_ready_in = 1'b1;
    push_cmd(5'd0, 1'b0, 8'h3C, 8'h0F);
    @(negedge clk);
    checks++;
    if (bus.res_valid_out !== 1'b0) $display("FAIL single_early_valid: got %b, required 0", bus.res_valid_out);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.alu_sel_out, bus.alu_carry_out, bus.alu_a_out, bus.alu_b_out, bus.res_valid_out} !==
        {5'd0, 1'b0, 8'h3C, 8'h0F, 1'b0})
      $display("FAIL single_alu_drive: got sel=%0d c=%b a=%h b=%h v=%b, required 0 0 3c 0f 0",
               bus.alu_sel_out, bus.alu_carry_out, bus.alu_a_out, bus.alu_b_out, bus.res_valid_out);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.res_zero_out} !== {1'b1, 8'h4B, 5'd0, 1'b0})
      $display("FAIL single_result: got v=%b y=%h sel=%0d z=%b, required 1 4b 0 0",
               bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.res_zero_out);
    else passed++;
    @(posedge clk); #1;
    wait_drain("single_drain");
  endtask

  task automatic test_wrap_zero();
    bit seen = 1'b0;
    bus.res_ready_in = 1'b0;
    push_cmd(5'd3, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || bus.res_y_out !== 8'h00 || bus.res_zero_out !== 1'b1)
      $display("FAIL wrap_zero: got v=%b y=%h z=%b, required 1 00 1", seen, bus.res_y_out, bus.res_zero_out);
    else passed++;
    @(posedge clk); #1;
    bus.res_ready_in = 1'b1;
    wait_drain("wrap_drain");
  endtask

  task automatic test_full();
    bus.res_ready_in = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(5'(i + 1), i[0], 8'(8'h10 * i), 8'(i + 3));
    bus.cmd_valid_in = 1'b1;
    bus.cmd_sel_in   = 5'd6;
    bus.cmd_carry_in = 1'b1;
    bus.cmd_a_in     = 8'hA0;
    bus.cmd_b_in     = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready_out, bus.res_valid_out, bus.busy_out} !== 3'b011)
        $display("FAIL full_ready: got ready=%b valid=%b busy=%b, required 0 1 1",
                 bus.cmd_ready_out, bus.res_valid_out, bus.busy_out);
      else passed++;
      @(posedge clk); #1;
    end
    bus.res_ready_in = 1'b1;
    push_cmd(5'd6, 1'b1, 8'hA0, 8'h05);
    wait_drain("full_drain");
  endtask

  task automatic test_stream();
    bus.res_ready_in = 1'b1;
    res_cyc.delete();
    for (int i = 0; i < 8; i++)
      push_cmd(5'd2, 1'b0, 8'(i), 8'(i));
    wait_drain("stream_drain");
    checks++;
    if (res_cyc.size() != 8) $display("FAIL stream_count: got %0d results, required 8", res_cyc.size());
    else passed++;
    for (int k = 1; k < res_cyc.size(); k++) begin
      checks++;
      if (res_cyc[k] - res_cyc[k-1] != 2)
        $display("FAIL stream_spacing: got %0d cycles at result %0d, required 2", res_cyc[k] - res_cyc[k-1], k);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    bus.res_ready_in = 1'b0;
    push_cmd(5'd9, 1'b0, 8'h55, 8'h22);
    push_cmd(5'd4, 1'b1, 8'h10, 8'h20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!seen || {bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.alu_sel_out,
                    bus.alu_carry_out, bus.alu_a_out, bus.alu_b_out} !==
                   {1'b1, 8'h77, 5'd9, 5'd9, 1'b0, 8'h55, 8'h22})
        $display("FAIL bp_hold: got v=%b y=%h sel=%0d alu_a=%h alu_b=%h, required 1 77 9 55 22",
                 bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.alu_a_out, bus.alu_b_out);
      else passed++;
      @(posedge clk); #1;
    end
    bus.res_ready_in = 1'b1;
    wait_drain("bp_drain");
  endtask

  task automatic test_reset_mid();
    bus.res_ready_in = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(5'(i + 20), 1'b0, 8'(i + 1), 8'h40);
    bus.res_ready_in = 1'b1;
    @(posedge clk); #1;
    bus.res_ready_in = 1'b0;
    checks++;
    if ({bus.res_valid_out, bus.busy_out, bus.alu_a_out} !== {1'b0, 1'b1, 8'h02})
      $display("FAIL mid_settle: got v=%b busy=%b alu_a=%h, required 0 1 02",
               bus.res_valid_out, bus.busy_out, bus.alu_a_out);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready_out, bus.alu_sel_out, bus.alu_carry_out, bus.alu_a_out, bus.alu_b_out,
         bus.res_valid_out, bus.res_y_out, bus.res_sel_out, bus.res_zero_out, bus.busy_out} !== '0)
      $display("FAIL mid_reset_outputs: got ready=%b alu_a=%h v=%b busy=%b, required all 0",
               bus.cmd_ready_out, bus.alu_a_out, bus.res_valid_out, bus.busy_out);
    else passed++;
    exp_q.delete();
    bus.res_ready_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.res_valid_out, bus.busy_out, bus.cmd_ready_out} !== 3'b000)
      $display("FAIL mid_release: got v=%b busy=%b ready=%b, required 0 0 0",
               bus.res_valid_out, bus.busy_out, bus.cmd_ready_out);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready_out !== 1'b1) $display("FAIL mid_ready: got %b, required 1", bus.cmd_ready_out);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.res_valid_out, bus.busy_out} !== 2'b00)
        $display("FAIL mid_no_result: got v=%b busy=%b, required 0 0", bus.res_valid_out, bus.busy_out);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cmd_valid_in = 1'b0;
    bus.cmd_sel_in   = '0;
    bus.cmd_carry_in = 1'b0;
    bus.cmd_a_in     = '0;
    bus.cmd_b_in     = '0;
    bus.res_ready_in = 1'b0;
    test_reset();
    test_single();
    test_wrap_zero();
    test_full();
    test_stream();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
